// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 16;
    localparam int          FETCH_DATA_W   = 16;
    localparam int unsigned FETCH_RESET_PC = 0;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DONE,
        HALTED
    } fetch_state_t;

    // One prefetch-buffer slot: the word and the address it came from.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] word;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer signal bundle: memory port, decode handshake,
// control requests and status.
interface fetch_sequencer_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              busy;
    logic              done;
    logic              halted;

    // Sequencer side.
    modport master (
        input  start, imem_data, inst_ready, redirect_valid, redirect_pc, halt_req,
        output imem_addr, inst, inst_pc, inst_valid, busy, done, halted
    );

    // Environment side: memory, decode and control.
    modport slave (
        output start, imem_data, inst_ready, redirect_valid, redirect_pc, halt_req,
        input  imem_addr, inst, inst_pc, inst_valid, busy, done, halted
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for the prefetch buffer. Flush wins over push/pop.
// Head reads as zero when empty so downstream sees clean outputs.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  BUF_DEPTH = 2,
    parameter type entry_t   = fetch_entry_t,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  entry_t           i_din,
    output logic [CNT_W-1:0] o_count,
    output entry_t           o_head
);

    entry_t           r_mem [BUF_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr;
    logic             w_rd;

    assign w_wr = i_push && !i_flush;
    assign w_rd = i_pop  && !i_flush;

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_din;
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_wr && !w_rd && r_count == CNT_W'(BUF_DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_rd && r_count == '0));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: walks the PC through instruction memory,
// buffers returned words and hands them to decode with valid/ready.
// Priority of requests: start > halt_req > redirect_valid > normal fetch.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          ADDR_W    = FETCH_ADDR_W,
    parameter int          DATA_W    = FETCH_DATA_W,
    parameter int          PROG_LEN  = 25,
    parameter int unsigned RESET_PC  = FETCH_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic [CNT_W-1:0]  w_count;
    logic              w_valid;
    logic              w_in_prog;
    logic              w_has_room;
    entry_t            w_din;
    entry_t            w_head;

    assign w_valid    = (w_count != '0);
    assign w_pop      = w_valid && bus.inst_ready;
    assign w_in_prog  = (r_fetch_pc < ADDR_W'(PROG_LEN));
    assign w_has_room = (w_count < CNT_W'(BUF_DEPTH));
    assign w_din      = '{pc: r_fetch_pc, word: bus.imem_data};

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    // Next state, next PC and buffer control, in request priority order.
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_flush        = 1'b0;
        if (bus.start) begin
            w_state_nxt    = FETCH;
            w_fetch_pc_nxt = ADDR_W'(RESET_PC);
            w_flush        = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_fetch_pc_nxt = ADDR_W'(RESET_PC);
                    w_flush        = 1'b1;
                end
                FETCH, DONE: begin
                    if (bus.halt_req) begin
                        w_state_nxt = HALTED;
                        w_flush     = 1'b1;
                    end else if (bus.redirect_valid) begin
                        // Out-of-range targets fall through to DONE next cycle.
                        w_state_nxt    = FETCH;
                        w_fetch_pc_nxt = bus.redirect_pc;
                        w_flush        = 1'b1;
                    end else if (r_state == FETCH) begin
                        if (w_in_prog && (w_has_room || w_pop)) begin
                            w_push         = 1'b1;
                            w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(1);
                        end else if (!w_in_prog && w_count == '0) begin
                            w_state_nxt = DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .entry_t   (entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (w_din),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst       = w_head.word;
    assign bus.inst_pc    = w_head.pc;
    assign bus.inst_valid = w_valid;
    assign bus.busy       = (r_state == FETCH);
    assign bus.done       = (r_state == DONE);
    assign bus.halted     = (r_state == HALTED);

endmodule
